msb_byte_packer: RTL and testbench

Packs a stream of partially filled, MSB-aligned byte words into dense full words. It sits directly upstream of the MSB thermometer-mask stage. Each input beat carries a byte count. The block concatenates the valid bytes across beats and emits full `BYTES`-wide words. On `last_i` it flushes the remaining bytes as a final partial word, whose `len_o` is the count the downstream mask stage consumes.

---
 rtl/msb_byte_packer.sv | 133 +++++++++++++
 tb/tb_msb_byte_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msb_byte_packer.sv
// rtl/msb_byte_packer.sv - packs MSB-aligned partial byte words into dense full words
// Optional zero fill of unused bytes: define MSB_PACKER_ZERO_PAD_EN.
module msb_byte_packer #(
  parameter int BYTES = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [BYTES*8-1:0] data_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               last_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [BYTES*8-1:0] data_o,
  output logic [LEN_W-1:0]   len_o,
  output logic               last_o
);
  localparam int W     = BYTES * 8;
  localparam int IDX_W = $clog2(2 * BYTES);

  logic [W-1:0]     res_q, res_d, data_q, data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             last_q, last_d, valid_q, valid_d, flush_q, flush_d;

  logic             out_free, accept;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W:0]   sum;
  logic [W-1:0]     din_m, hi_w, lo_w;
  logic [7:0]       mb [2*BYTES];
  logic [IDX_W-1:0] idx;

  assign out_free = !valid_q || ready_i;
  assign ready_o  = out_free && !flush_q;
  assign accept   = valid_i && ready_o;
  assign len_c    = (len_i > LEN_W'(BYTES)) ? LEN_W'(BYTES) : len_i;
  assign sum      = {1'b0, cnt_q} + {1'b0, len_c};

  // Merged stream of 2*BYTES bytes: res[0..cnt-1] then input bytes shifted right by cnt.
  always_comb begin
    din_m = data_i;
`ifdef MSB_PACKER_ZERO_PAD_EN
    for (int k = 0; k < BYTES; k++) begin
      if (LEN_W'(k) >= len_c) din_m[W-1-8*k -: 8] = 8'h00;
    end
`endif
    for (int j = 0; j < 2 * BYTES; j++) mb[j] = 8'h00;
    idx = '0;
    for (int k = 0; k < BYTES; k++) begin
      idx     = IDX_W'(k) + IDX_W'(cnt_q);
      mb[idx] = din_m[W-1-8*k -: 8];
    end
    for (int j = 0; j < BYTES; j++) begin
      if (LEN_W'(j) < cnt_q) mb[j] = res_q[W-1-8*j -: 8];
    end
    hi_w = '0;
    lo_w = '0;
    for (int j = 0; j < BYTES; j++) begin
      hi_w[W-1-8*j -: 8] = mb[j];
      lo_w[W-1-8*j -: 8] = mb[j+BYTES];
    end
  end

  always_comb begin
    res_d   = res_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    len_d   = len_q;
    last_d  = last_q;
    valid_d = valid_q && !ready_i;
    flush_d = flush_q;
    if (flush_q && out_free) begin
      data_d  = res_q;
      len_d   = cnt_q;
      last_d  = 1'b1;
      valid_d = 1'b1;
      cnt_d   = '0;
      flush_d = 1'b0;
`ifdef MSB_PACKER_ZERO_PAD_EN
      res_d   = '0;
`endif
    end else if (accept) begin
      if (sum < (LEN_W+1)'(BYTES) && !last_i) begin
        res_d = hi_w;
        cnt_d = sum[LEN_W-1:0];
      end else if (sum <= (LEN_W+1)'(BYTES)) begin
        // Covers the zero-length last word, so last is never dropped.
        data_d  = hi_w;
        len_d   = sum[LEN_W-1:0];
        last_d  = last_i;
        valid_d = 1'b1;
        cnt_d   = '0;
`ifdef MSB_PACKER_ZERO_PAD_EN
        res_d   = '0;
`endif
      end else begin
        data_d  = hi_w;
        len_d   = LEN_W'(BYTES);
        last_d  = 1'b0;
        valid_d = 1'b1;
        res_d   = lo_w;
        cnt_d   = LEN_W'(sum - (LEN_W+1)'(BYTES));
        flush_d = last_i;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      res_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      len_q   <= len_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign len_o   = len_q;
  assign last_o  = last_q;
endmodule

// File: tb/tb_msb_byte_packer.sv
// tb/tb_msb_byte_packer.sv - directed and random bench for msb_byte_packer against a byte-queue model
// Honours MSB_PACKER_ZERO_PAD_EN when comparing bytes beyond len_o.
module tb_msb_byte_packer;
  logic        clk = 1'b0;
  logic        nreset;
  logic        valid_i, ready_o, last_i, valid_o, ready_i, last_o;
  logic [63:0] data_i, data_o;
  logic [3:0]  len_i, len_o;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;

  typedef struct {
    logic [63:0] data;
    int          len;
    logic        last;
  } word_t;

  logic [7:0] pend [$];
  word_t      exp_q [$];

  logic        prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic [3:0]  prev_len;
  logic        prev_last;

  msb_byte_packer #(.BYTES(8), .LEN_W(4)) dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .len_i(len_i), .last_i(last_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .len_o(len_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lenmask(input int n);
    logic [63:0] m = '0;
    for (int k = 0; k < 8; k++) if (k < n) m[63-8*k -: 8] = 8'hff;
    return m;
  endfunction

  // Reference: concatenate packet bytes, cut into 8-byte words, flush the tail on last.
  function automatic void model_beat(input int l, input logic [63:0] d, input logic lst);
    int    lc = (l > 8) ? 8 : l;
    bit    got_last = 0;
    word_t w;
    for (int k = 0; k < lc; k++) pend.push_back(d[63-8*k -: 8]);
    while (pend.size() >= 8) begin
      w.data = '0;
      for (int k = 0; k < 8; k++) w.data[63-8*k -: 8] = pend.pop_front();
      w.len  = 8;
      w.last = lst && (pend.size() == 0);
      if (w.last) got_last = 1;
      exp_q.push_back(w);
    end
    if (lst && !got_last) begin
      w.data = '0;
      w.len  = pend.size();
      for (int k = 0; k < w.len; k++) w.data[63-8*k -: 8] = pend[k];
      w.last = 1'b1;
      exp_q.push_back(w);
      pend.delete();
    end
  endfunction

  task automatic drive_ready();
    if (bp_mode == 0) ready_i = 1'b1;
    else if (bp_mode == 1) ready_i = ($urandom % 4) != 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] l, input logic [63:0] d, input logic lst);
    int g = 0;
    valid_i = 1'b1;
    len_i   = l;
    data_i  = d;
    last_i  = lst;
    drive_ready();
    #1;
    while (!ready_o && g < 200) begin
      step();
      drive_ready();
      #1;
      g++;
    end
    if (g >= 200) chk("send_ready_timeout", ready_o, 1);
    model_beat(int'(l), d, lst);
    step();
    valid_i = 1'b0;
  endtask

  always @(negedge clk) begin
    word_t w;
    if (nreset) begin
      if (prev_hold) begin
        chk("hold_data", data_o, prev_data);
        chk("hold_len", len_o, prev_len);
        chk("hold_last", last_o, prev_last);
        chk("hold_valid", valid_o, 1);
      end
      if (valid_o && !ready_i) chk("hold_ready_o", ready_o, 0);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_word", valid_o, 0);
        else begin
          w = exp_q.pop_front();
          chk("word_len", len_o, w.len);
          chk("word_last", last_o, w.last);
`ifdef MSB_PACKER_ZERO_PAD_EN
          chk("word_data", data_o, w.data);
`else
          chk("word_data", data_o & lenmask(w.len), w.data & lenmask(w.len));
`endif
        end
      end
    end
    prev_hold = nreset && valid_o && !ready_i;
    prev_data = data_o;
    prev_len  = len_o;
    prev_last = last_o;
  end

  initial begin
    logic [63:0] d0, rd;
    logic [3:0]  l0;
    logic        t0;
    int          g;
    nreset  = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    len_i   = '0;
    last_i  = 1'b0;
    ready_i = 1'b0;
    repeat (2) step();
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_len_o", len_o, 0);
    chk("rst_last_o", last_o, 0);
    nreset = 1'b1;
    #1;
    chk("rst_ready_o", ready_o, 1);
    step();

    // Merge: 3 + 5 bytes with last -> one full last word one cycle later.
    bp_mode = 0;
    send(4'd3, 64'hA1A2A3_EEEEEEEEEE, 1'b0);
    send(4'd5, 64'hB1B2B3B4B5_DDDDDD, 1'b1);
    chk("merge_valid", valid_o, 1);
    chk("merge_len", len_o, 8);
    chk("merge_last", last_o, 1);
    chk("merge_data", data_o, 64'hA1A2A3B1B2B3B4B5);

    // Overflow flush: 6 + 6 bytes with last.
    send(4'd6, 64'hA1A2A3A4A5A6_CCCC, 1'b0);
    send(4'd6, 64'hB1B2B3B4B5B6_CCCC, 1'b1);
    chk("ovf_len0", len_o, 8);
    chk("ovf_last0", last_o, 0);
    chk("ovf_data0", data_o, 64'hA1A2A3A4A5A6B1B2);
    chk("ovf_ready_flush", ready_o, 0);
    step();
    chk("ovf_valid1", valid_o, 1);
    chk("ovf_len1", len_o, 4);
    chk("ovf_last1", last_o, 1);
    chk("ovf_data1", data_o & lenmask(4), 64'hB3B4B5B6_00000000);

    // Backpressure on the flush word for 3 cycles.
    bp_mode = 2;
    ready_i = 1'b0;
    d0 = data_o;
    l0 = len_o;
    t0 = last_o;
    repeat (3) begin
      step();
      chk("bp_data", data_o, d0);
      chk("bp_len", len_o, l0);
      chk("bp_last", last_o, t0);
      chk("bp_ready_o", ready_o, 0);
    end
    ready_i = 1'b1;
    step();
    chk("bp_done", valid_o, 0);

    // Empty last.
    bp_mode = 0;
    send(4'd0, {$urandom, $urandom}, 1'b1);
    chk("empty_valid", valid_o, 1);
    chk("empty_len", len_o, 0);
    chk("empty_last", last_o, 1);
`ifdef MSB_PACKER_ZERO_PAD_EN
    chk("empty_data", data_o, 0);
`endif
    step();

    // Streaming: 16 full beats back to back.
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1;
      len_i   = 4'd8;
      data_i  = {$urandom, $urandom};
      last_i  = (i == 15);
      ready_i = 1'b1;
      #1;
      chk("stream_ready", ready_o, 1);
      if (i > 0) chk("stream_valid", valid_o, 1);
      model_beat(8, data_i, last_i);
      step();
    end
    valid_i = 1'b0;
    chk("stream_valid_end", valid_o, 1);
    step();
    chk("stream_idle", valid_o, 0);

    // Reset mid-packet with cnt=5 and a word pending.
    send(4'd6, {$urandom, $urandom}, 1'b0);
    send(4'd7, {$urandom, $urandom}, 1'b0);
    nreset = 1'b0;
    pend.delete();
    exp_q.delete();
    #1;
    chk("midrst_valid", valid_o, 0);
    step();
    nreset = 1'b1;
    step();
    chk("midrst_ready", ready_o, 1);
    rd = {$urandom, $urandom};
    send(4'd8, rd, 1'b1);
    chk("midrst_word", data_o, rd);
    chk("midrst_len", len_o, 8);
    chk("midrst_last", last_o, 1);
    step();
    chk("midrst_no_residual", valid_o, 0);

    // Random beats with random backpressure, lengths up to 10 to exercise clamping.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 10)), {$urandom, $urandom}, ($urandom % 5) == 0);
      if (($urandom % 4) == 0) begin
        drive_ready();
        step();
      end
    end
    send(4'd1, {$urandom, $urandom}, 1'b1);

    bp_mode = 0;
    ready_i = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      step();
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    step();
    chk("final_idle", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
